lagd_ising_ctrl: RTL and testbench

Per-core run controller that sits directly downstream of the SoC external register-interface port, one instance per Ising core slot. It exposes a small control/status register file to the host and sequences an annealing run: it issues one start pulse per iteration to the core datapath, counts completed iterations, applies a per-iteration watchdog, and raises a level interrupt on completion, abort or timeout.

---
 rtl/lagd_ising_ctrl_pkg.sv | 43 ++++
 rtl/lagd_ising_ctrl_regfile.sv | 161 ++++++++++++++++
 rtl/lagd_ising_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lagd_ising_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lagd_ising_ctrl_pkg.sv
// Shared definitions for the Ising-core run controller.
// Holds the register map (word indices decoded from address bits [4:2]),
// CTRL/STATUS bit positions, the sticky-flag layout, the run FSM state
// type and the register-interface field widths.
package lagd_ising_ctrl_pkg;

  // Register-interface field widths.
  localparam int RegDataWidth = 32;
  localparam int RegStrbWidth = 4;
  localparam int RegIdxWidth  = 3;

  // Register word indices; byte offset = index * 4.
  localparam logic [RegIdxWidth-1:0] IdxCtrl    = 3'd0;  // 0x00
  localparam logic [RegIdxWidth-1:0] IdxStatus  = 3'd1;  // 0x04
  localparam logic [RegIdxWidth-1:0] IdxNumIter = 3'd2;  // 0x08
  localparam logic [RegIdxWidth-1:0] IdxIterCnt = 3'd3;  // 0x0C
  localparam logic [RegIdxWidth-1:0] IdxTimeout = 3'd4;  // 0x10

  // CTRL bits.
  localparam int CtrlStartBit = 0;
  localparam int CtrlAbortBit = 1;
  localparam int CtrlIrqEnBit = 2;

  // STATUS bits.
  localparam int StatBusyBit    = 0;
  localparam int StatDoneBit    = 1;
  localparam int StatAbortedBit = 2;
  localparam int StatTimeoutBit = 3;

  // Sticky flags are kept as a 3-bit vector; STATUS = {flags, busy}, so
  // flag index i lands on STATUS bit i+1.
  localparam int NumFlags    = 3;
  localparam int FlagDone    = 0;
  localparam int FlagAborted = 1;
  localparam int FlagTimeout = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StWait   = 2'd2
  } state_e;

endpackage

// File: rtl/lagd_ising_ctrl_regfile.sv
// Control/status register file of the run controller.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   reg_*                host register-interface request/response
//   busy_i               run FSM is not idle
//   iter_cnt_i           completed-iteration count (read-only view)
//   flag_set_i/clr_i     sticky-flag set/clear requests from the FSM
//   start_o, abort_o     one-cycle CTRL.START / CTRL.ABORT strobes
//   num_iter_o, timeout_o  configuration values
//   irq_o                registered level interrupt
//
// Handshake: a request is accepted in the first cycle reg_valid_i is seen
// while no response is pending (cycle N). Read data and error are captured
// from the state in cycle N and presented with reg_ready_o in N+1; the
// request is latched in N and its write side effects commit at the edge
// ending N+1. reg_ready_o never stays high two cycles, because the host
// still holds valid during the response cycle and that cycle is not
// eligible for acceptance.
module lagd_ising_ctrl_regfile
  import lagd_ising_ctrl_pkg::*;
#(
  parameter int AddrWidth    = 8,
  parameter int IterWidth    = 16,
  parameter int TimeoutWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    reg_valid_i,
  input  logic                    reg_write_i,
  input  logic [AddrWidth-1:0]    reg_addr_i,
  input  logic [RegDataWidth-1:0] reg_wdata_i,
  input  logic [RegStrbWidth-1:0] reg_wstrb_i,
  output logic                    reg_ready_o,
  output logic [RegDataWidth-1:0] reg_rdata_o,
  output logic                    reg_error_o,
  input  logic                    busy_i,
  input  logic [IterWidth-1:0]    iter_cnt_i,
  input  logic [NumFlags-1:0]     flag_set_i,
  input  logic [NumFlags-1:0]     flag_clr_i,
  output logic                    start_o,
  output logic                    abort_o,
  output logic [IterWidth-1:0]    num_iter_o,
  output logic [TimeoutWidth-1:0] timeout_o,
  output logic                    irq_o
);

  logic                    ready_q;
  logic [RegDataWidth-1:0] rdata_q, rdata_d;
  logic                    error_q, error_d;
  logic                    wr_q;
  logic [RegIdxWidth-1:0]  idx_q;
  logic [RegDataWidth-1:0] wdata_q;
  logic [RegStrbWidth-1:0] wstrb_q;

  logic                    irq_en_q, irq_en_d;
  logic [NumFlags-1:0]     flags_q, flags_d;
  logic [IterWidth-1:0]    num_iter_q, num_iter_d;
  logic [TimeoutWidth-1:0] timeout_q, timeout_d;
  logic                    irq_q;

  logic                   accept;
  logic                   commit;
  logic [RegIdxWidth-1:0] idx;

  assign accept = reg_valid_i & ~ready_q;
  assign idx    = reg_addr_i[4:2];
  // A write that was flagged as an error has no side effect.
  assign commit = ready_q & wr_q & ~error_q;

  // Address bits outside [4:2] and wide write fields are not decoded.
  logic unused_bits;
  assign unused_bits = ^{reg_addr_i[AddrWidth-1:5], reg_addr_i[1:0], wdata_q, wstrb_q};

  // Response captured in the acceptance cycle.
  always_comb begin
    rdata_d = '0;
    error_d = 1'b0;
    case (idx)
      IdxCtrl:    rdata_d[CtrlIrqEnBit] = irq_en_q;
      IdxStatus:  rdata_d[StatTimeoutBit:StatBusyBit] = {flags_q, busy_i};
      IdxNumIter: rdata_d[IterWidth-1:0] = num_iter_q;
      IdxIterCnt: rdata_d[IterWidth-1:0] = iter_cnt_i;
      IdxTimeout: rdata_d[TimeoutWidth-1:0] = timeout_q;
      default:    error_d = 1'b1;
    endcase
    if (reg_write_i) begin
      rdata_d = '0;
      // Configuration is frozen while a run is in progress.
      if (busy_i && (idx == IdxNumIter || idx == IdxTimeout)) error_d = 1'b1;
    end
  end

  assign start_o = commit && (idx_q == IdxCtrl) && wstrb_q[0] && wdata_q[CtrlStartBit];
  assign abort_o = commit && (idx_q == IdxCtrl) && wstrb_q[0] && wdata_q[CtrlAbortBit];

  always_comb begin
    irq_en_d   = irq_en_q;
    num_iter_d = num_iter_q;
    timeout_d  = timeout_q;
    flags_d    = flags_q & ~flag_clr_i;
    if (commit) begin
      case (idx_q)
        IdxCtrl: if (wstrb_q[0]) irq_en_d = wdata_q[CtrlIrqEnBit];
        IdxStatus: if (wstrb_q[0]) flags_d = flags_d & ~wdata_q[StatTimeoutBit:StatDoneBit];
        IdxNumIter: begin
          for (int b = 0; b < IterWidth; b++) begin
            if (wstrb_q[b/8]) num_iter_d[b] = wdata_q[b];
          end
        end
        IdxTimeout: begin
          for (int b = 0; b < TimeoutWidth; b++) begin
            if (wstrb_q[b/8]) timeout_d[b] = wdata_q[b];
          end
        end
        default: ;
      endcase
    end
    // A hardware set in the same cycle as a host W1C wins.
    flags_d = flags_d | flag_set_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      irq_en_q   <= 1'b0;
      flags_q    <= '0;
      num_iter_q <= '0;
      timeout_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      ready_q <= accept;
      if (accept) begin
        rdata_q <= rdata_d;
        error_q <= error_d;
        wr_q    <= reg_write_i;
        idx_q   <= idx;
        wdata_q <= reg_wdata_i;
        wstrb_q <= reg_wstrb_i;
      end
      irq_en_q   <= irq_en_d;
      flags_q    <= flags_d;
      num_iter_q <= num_iter_d;
      timeout_q  <= timeout_d;
      irq_q      <= irq_en_q & (|flags_q);
    end
  end

  assign reg_ready_o = ready_q;
  assign reg_rdata_o = ready_q ? rdata_q : '0;
  assign reg_error_o = ready_q & error_q;
  assign num_iter_o  = num_iter_q;
  assign timeout_o   = timeout_q;
  assign irq_o       = irq_q;

endmodule

// File: rtl/lagd_ising_ctrl.sv
// Per-core annealing run controller.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   reg_*               host register interface (see regfile)
//   core_start_o        one-cycle launch pulse per iteration
//   core_abort_o        one-cycle abort pulse on host abort or watchdog
//   core_iter_done_i    one-cycle iteration-complete pulse from the core
//   irq_o               level interrupt on done/abort/timeout
// Sequences IDLE -> LAUNCH -> WAIT -> (LAUNCH | IDLE), counting completed
// iterations and timing each WAIT with a watchdog.
module lagd_ising_ctrl
  import lagd_ising_ctrl_pkg::*;
#(
  parameter int AddrWidth    = 8,
  parameter int IterWidth    = 16,
  parameter int TimeoutWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    reg_valid_i,
  input  logic                    reg_write_i,
  input  logic [AddrWidth-1:0]    reg_addr_i,
  input  logic [RegDataWidth-1:0] reg_wdata_i,
  input  logic [RegStrbWidth-1:0] reg_wstrb_i,
  output logic                    reg_ready_o,
  output logic [RegDataWidth-1:0] reg_rdata_o,
  output logic                    reg_error_o,
  output logic                    core_start_o,
  output logic                    core_abort_o,
  input  logic                    core_iter_done_i,
  output logic                    irq_o
);

  state_e                  state_q, state_d;
  logic [IterWidth-1:0]    iter_cnt_q, iter_cnt_d;
  logic [TimeoutWidth-1:0] wd_q, wd_d;
  logic                    abort_q, abort_d;

  logic [NumFlags-1:0]     flag_set, flag_clr;
  logic                    start_req, abort_req, busy;
  logic [IterWidth-1:0]    num_iter;
  logic [TimeoutWidth-1:0] timeout;

  lagd_ising_ctrl_regfile #(
    .AddrWidth   (AddrWidth),
    .IterWidth   (IterWidth),
    .TimeoutWidth(TimeoutWidth)
  ) u_regfile (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .reg_valid_i(reg_valid_i),
    .reg_write_i(reg_write_i),
    .reg_addr_i (reg_addr_i),
    .reg_wdata_i(reg_wdata_i),
    .reg_wstrb_i(reg_wstrb_i),
    .reg_ready_o(reg_ready_o),
    .reg_rdata_o(reg_rdata_o),
    .reg_error_o(reg_error_o),
    .busy_i     (busy),
    .iter_cnt_i (iter_cnt_q),
    .flag_set_i (flag_set),
    .flag_clr_i (flag_clr),
    .start_o    (start_req),
    .abort_o    (abort_req),
    .num_iter_o (num_iter),
    .timeout_o  (timeout),
    .irq_o      (irq_o)
  );

  // Saturating increments: ITER_CNT never wraps, and a stuck watchdog
  // with TIMEOUT=0 simply parks at its maximum.
  logic [IterWidth-1:0]    cnt_inc;
  logic [TimeoutWidth-1:0] wd_inc;
  logic                    wd_expire;

  assign cnt_inc = (&iter_cnt_q) ? iter_cnt_q : iter_cnt_q + 1'b1;
  assign wd_inc  = (&wd_q) ? wd_q : wd_q + 1'b1;
  // Expiry is decided in the last quiet WAIT cycle so the abort pulse
  // (registered) lands exactly TIMEOUT cycles after entering WAIT.
  assign wd_expire = (timeout != '0) &&
                     (({1'b0, wd_q} + {{TimeoutWidth{1'b0}}, 1'b1}) == {1'b0, timeout});

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      iter_cnt_q <= '0;
      wd_q       <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
      wd_q       <= wd_d;
      abort_q    <= abort_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    wd_d       = wd_q;
    abort_d    = 1'b0;
    flag_set   = '0;
    flag_clr   = '0;
    case (state_q)
      StIdle: begin
        if (start_req) begin
          iter_cnt_d = '0;
          if (num_iter != '0) begin
            flag_clr = '1;
            state_d  = StLaunch;
          end else begin
            flag_set[FlagDone] = 1'b1;
          end
        end
      end
      StLaunch: begin
        wd_d    = '0;
        state_d = StWait;
        if (abort_req) begin
          state_d               = StIdle;
          flag_set[FlagAborted] = 1'b1;
          abort_d               = 1'b1;
        end
      end
      StWait: begin
        if (core_iter_done_i) begin
          // A done pulse beats a simultaneous watchdog expiry.
          iter_cnt_d = cnt_inc;
          if (cnt_inc == num_iter) begin
            state_d            = StIdle;
            flag_set[FlagDone] = 1'b1;
          end else begin
            state_d = StLaunch;
          end
        end else if (wd_expire) begin
          state_d               = StIdle;
          flag_set[FlagTimeout] = 1'b1;
          abort_d               = 1'b1;
        end else begin
          wd_d = wd_inc;
        end
        // Host abort wins over completion; the count above still stands.
        if (abort_req) begin
          state_d  = StIdle;
          flag_set = '0;
          flag_set[FlagAborted] = 1'b1;
          abort_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    core_start_o = (state_q == StLaunch);
    busy         = (state_q != StIdle);
    core_abort_o = abort_q;
  end

endmodule

// File: tb/tb_lagd_ising_ctrl.sv
// Self-checking bench for lagd_ising_ctrl: directed register/run steps plus
// randomized runs compared against an iteration-level model of a run.
module tb_lagd_ising_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_valid_i;
  logic        reg_write_i;
  logic [7:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [3:0]  reg_wstrb_i;
  logic        reg_ready_o;
  logic [31:0] reg_rdata_o;
  logic        reg_error_o;
  logic        core_start_o;
  logic        core_abort_o;
  logic        core_iter_done_i;
  logic        irq_o;

  lagd_ising_ctrl #(
    .AddrWidth(8), .IterWidth(16), .TimeoutWidth(16)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .reg_valid_i     (reg_valid_i),
    .reg_write_i     (reg_write_i),
    .reg_addr_i      (reg_addr_i),
    .reg_wdata_i     (reg_wdata_i),
    .reg_wstrb_i     (reg_wstrb_i),
    .reg_ready_o     (reg_ready_o),
    .reg_rdata_o     (reg_rdata_o),
    .reg_error_o     (reg_error_o),
    .core_start_o    (core_start_o),
    .core_abort_o    (core_abort_o),
    .core_iter_done_i(core_iter_done_i),
    .irq_o           (irq_o)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- core responder ----------------
  // resp_lat>0: answer each start with a done pulse resp_lat cycles later.
  // force_done: main sequence injects a done pulse in the current cycle.
  int   resp_lat = 0;
  logic force_done = 1'b0;

  initial begin
    int  cd;
    logic hit;
    cd = 0;
    core_iter_done_i = 1'b0;
    forever begin
      @(posedge clk); #2;
      hit = (cd == 1);
      if (cd > 0) cd--;
      if (rst) cd = 0;
      else if (core_start_o && resp_lat > 0) cd = resp_lat;
      core_iter_done_i = hit | force_done;
    end
  end

  // ---------------- monitor ----------------
  int   start_q[$];
  int   abort_q[$];
  int   done_q[$];
  int   irq_rise = -1;
  initial begin
    logic irq_prev;
    irq_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (core_start_o === 1'b1) start_q.push_back(cyc);
      if (core_abort_o === 1'b1) abort_q.push_back(cyc);
      if (core_iter_done_i === 1'b1) done_q.push_back(cyc);
      if (irq_o === 1'b1 && !irq_prev) irq_rise = cyc;
      irq_prev = (irq_o === 1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  int last_req_cyc = 0;

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, output logic [31:0] rdata, output logic err);
    int n;
    reg_valid_i = 1'b1;
    reg_write_i = wr;
    reg_addr_i  = addr;
    reg_wdata_i = wdata;
    reg_wstrb_i = wstrb;
    last_req_cyc = cyc;
    rdata = 'x;
    err   = 1'bx;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (reg_ready_o !== 1'b1 && n < 8);
    if (reg_ready_o === 1'b1) begin
      rdata = reg_rdata_o;
      err   = reg_error_o;
    end
    reg_valid_i = 1'b0;
    reg_write_i = 1'b0;
    reg_wdata_i = '0;
    reg_wstrb_i = '0;
    check("ack_latency", 32'(n), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input logic [7:0] addr, input logic [31:0] exp,
                        input logic exp_err, input string tag);
    logic [31:0] d;
    logic        e;
    xfer(1'b0, addr, 32'h0, 4'h0, d, e);
    check({tag, "_rdata"}, d, exp);
    check({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
  endtask

  task automatic wr_chk(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input logic exp_err, input string tag);
    logic [31:0] d;
    logic        e;
    xfer(1'b1, addr, data, strb, d, e);
    check({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
  endtask

  // One run checked against an iteration-level model: every iteration
  // answered within the watchdog window completes; otherwise the first
  // iteration times out after exactly tmo WAIT cycles.
  task automatic do_run(input int ni, input int lat, input int tmo, input string tag);
    int  s0, a0, n;
    int  req;
    bit  completes;
    completes = (lat != 0) && (tmo == 0 || lat <= tmo);
    wr_chk(8'h08, 32'(ni), 4'hF, 1'b0, {tag, "_ni"});
    wr_chk(8'h10, 32'(tmo), 4'hF, 1'b0, {tag, "_to"});
    resp_lat = lat;
    s0 = start_q.size();
    a0 = abort_q.size();
    wr_chk(8'h00, 32'h5, 4'hF, 1'b0, {tag, "_go"});
    req = last_req_cyc;
    n = 0;
    while (irq_o !== 1'b1 && n < 2000) begin cycles(1); n++; end
    check({tag, "_irq_seen"}, {31'b0, irq_o}, 32'd1);
    cycles(2);
    check({tag, "_start_lat"}, 32'(start_q[s0] - req), 32'd2);
    if (completes) begin
      check({tag, "_starts"}, 32'(start_q.size() - s0), 32'(ni));
      check({tag, "_aborts"}, 32'(abort_q.size() - a0), 32'd0);
      check({tag, "_spacing"}, 32'(start_q[start_q.size()-1] - start_q[s0]),
            32'((ni - 1) * (lat + 1)));
      check({tag, "_irq_time"}, 32'(irq_rise - done_q[done_q.size()-1]), 32'd2);
      rd_chk(8'h0C, 32'(ni), 1'b0, {tag, "_cnt"});
      rd_chk(8'h04, 32'h2, 1'b0, {tag, "_status"});
    end else begin
      check({tag, "_starts"}, 32'(start_q.size() - s0), 32'd1);
      check({tag, "_aborts"}, 32'(abort_q.size() - a0), 32'd1);
      check({tag, "_wdog"}, 32'(abort_q[abort_q.size()-1] - start_q[s0] - 1), 32'(tmo));
      check({tag, "_irq_time"}, 32'(irq_rise - abort_q[abort_q.size()-1]), 32'd1);
      rd_chk(8'h0C, 32'd0, 1'b0, {tag, "_cnt"});
      rd_chk(8'h04, 32'h8, 1'b0, {tag, "_status"});
    end
    resp_lat = 0;
    wr_chk(8'h04, 32'hE, 4'hF, 1'b0, {tag, "_w1c"});
    cycles(1);
    check({tag, "_irq_clr"}, {31'b0, irq_o}, 32'd0);
    cycles(8);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int a0, s0;
    int addrs[5];
    addrs = '{0, 4, 8, 12, 16};
    rst = 1'b1;
    reg_valid_i = 1'b0;
    reg_write_i = 1'b0;
    reg_addr_i  = '0;
    reg_wdata_i = '0;
    reg_wstrb_i = '0;
    cycles(3);
    rst = 1'b0;
    cycles(1);

    // Reset state.
    check("rst_irq", {31'b0, irq_o}, 32'd0);
    check("rst_start", {31'b0, core_start_o}, 32'd0);
    check("rst_abort", {31'b0, core_abort_o}, 32'd0);
    check("rst_ready", {31'b0, reg_ready_o}, 32'd0);
    foreach (addrs[i]) rd_chk(8'(addrs[i]), 32'd0, 1'b0, "rst_reg");
    rd_chk(8'h14, 32'd0, 1'b1, "bad_addr");

    // Three iterations, core answers 4 cycles after each start.
    do_run(3, 4, 0, "run3");

    // NUM_ITER = 0: immediate DONE, no launch.
    s0 = start_q.size();
    wr_chk(8'h08, 32'd0, 4'hF, 1'b0, "zero_ni");
    wr_chk(8'h00, 32'h5, 4'hF, 1'b0, "zero_go");
    rd_chk(8'h04, 32'h2, 1'b0, "zero_status");
    cycles(4);
    check("zero_starts", 32'(start_q.size() - s0), 32'd0);
    check("zero_irq", {31'b0, irq_o}, 32'd1);
    rd_chk(8'h0C, 32'd0, 1'b0, "zero_cnt");
    wr_chk(8'h04, 32'hE, 4'hF, 1'b0, "zero_w1c");

    // Watchdog with a silent core, then the done/expiry tie and one past it.
    do_run(5, 0, 10, "wdog");
    do_run(2, 5, 5, "tie");
    do_run(1, 6, 5, "tmo_edge");

    // Abort in the same cycle as the second done pulse.
    resp_lat = 0;
    wr_chk(8'h08, 32'd4, 4'hF, 1'b0, "ab_ni");
    wr_chk(8'h10, 32'd0, 4'hF, 1'b0, "ab_to");
    s0 = start_q.size();
    a0 = abort_q.size();
    wr_chk(8'h00, 32'h5, 4'hF, 1'b0, "ab_go");
    cycles(2);
    force_done = 1'b1;
    cycles(1);
    force_done = 1'b0;
    cycles(3);
    reg_valid_i = 1'b1;
    reg_write_i = 1'b1;
    reg_addr_i  = 8'h00;
    reg_wdata_i = 32'h6;
    reg_wstrb_i = 4'hF;
    cycles(1);
    check("ab_ready", {31'b0, reg_ready_o}, 32'd1);
    force_done  = 1'b1;
    reg_valid_i = 1'b0;
    reg_write_i = 1'b0;
    cycles(1);
    force_done = 1'b0;
    cycles(3);
    check("ab_starts", 32'(start_q.size() - s0), 32'd2);
    check("ab_aborts", 32'(abort_q.size() - a0), 32'd1);
    rd_chk(8'h0C, 32'd2, 1'b0, "ab_cnt");
    rd_chk(8'h04, 32'h4, 1'b0, "ab_status");
    rd_chk(8'h00, 32'h4, 1'b0, "ab_ctrl");
    wr_chk(8'h04, 32'hE, 4'hF, 1'b0, "ab_w1c");

    // Configuration writes while busy are refused.
    wr_chk(8'h08, 32'd2, 4'hF, 1'b0, "bz_ni");
    wr_chk(8'h00, 32'h5, 4'hF, 1'b0, "bz_go");
    wr_chk(8'h08, 32'hFFFF, 4'h1, 1'b1, "bz_ni_wr");
    rd_chk(8'h08, 32'd2, 1'b0, "bz_ni_kept");
    wr_chk(8'h10, 32'd7, 4'hF, 1'b1, "bz_to_wr");
    rd_chk(8'h10, 32'd0, 1'b0, "bz_to_kept");
    wr_chk(8'h00, 32'h5, 4'hF, 1'b0, "bz_restart");
    rd_chk(8'h04, 32'h1, 1'b0, "bz_status");
    a0 = abort_q.size();
    wr_chk(8'h00, 32'h6, 4'hF, 1'b0, "bz_abort");
    cycles(1);
    check("bz_aborts", 32'(abort_q.size() - a0), 32'd1);
    rd_chk(8'h04, 32'h4, 1'b0, "bz_status2");
    wr_chk(8'h08, 32'hFFFF, 4'h1, 1'b0, "idle_ni_wr");
    rd_chk(8'h08, 32'h00FF, 1'b0, "idle_ni");
    wr_chk(8'h18, 32'h1, 4'hF, 1'b1, "bad_wr");
    rd_chk(8'h04, 32'h4, 1'b0, "bad_wr_noeffect");
    wr_chk(8'h04, 32'h4, 4'hF, 1'b0, "bz_w1c");

    // Randomized runs against the model.
    for (int r = 0; r < 8; r++) begin
      int ni, lat, tmo, sel;
      ni  = int'($urandom_range(1, 5));
      lat = int'($urandom_range(1, 6));
      sel = int'($urandom_range(0, 2));
      if (sel == 0 || lat == 1) tmo = 0;
      else if (sel == 1) tmo = lat + int'($urandom_range(0, 3));
      else tmo = int'($urandom_range(1, lat - 1));
      do_run(ni, lat, tmo, $sformatf("rnd%0d", r));
    end

    // Reset in the middle of a run: back to idle, no abort pulse.
    resp_lat = 0;
    wr_chk(8'h08, 32'd3, 4'hF, 1'b0, "mr_ni");
    wr_chk(8'h10, 32'd0, 4'hF, 1'b0, "mr_to");
    wr_chk(8'h00, 32'h1, 4'hF, 1'b0, "mr_go");
    cycles(3);
    a0 = abort_q.size();
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("mr_start", {31'b0, core_start_o}, 32'd0);
    cycles(4);
    check("mr_aborts", 32'(abort_q.size() - a0), 32'd0);
    rd_chk(8'h04, 32'd0, 1'b0, "mr_status");
    rd_chk(8'h08, 32'd0, 1'b0, "mr_ni_clr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
